rf_wb_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback requesters: EXU (ALU results) and LSU (load data).
- Each requester uses a valid/ready handshake. Arbitration is round-robin, and the granted write goes to the register file through a registered output stage.
- A busy-bit scoreboard tracks destination registers with writes in flight. It stalls issue on read-after-write (RAW) and write-after-write (WAW) hazards.
- Sits between the execute/LSU stages and the register file, which has a synchronous write and combinational read.

---
 rtl/rf_wb_arbiter.sv | 119 +++++++++++
 tb/tb_rf_wb_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter (EXU/LSU) with a registered RF write port and busy-bit scoreboard.
// Optional define RF_WB_BYPASS_EN: early busy clear at accept plus forwarding outputs.
module rf_wb_arbiter #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  exu_valid,
   output logic                  exu_ready,
   input  logic [ADDR_WIDTH-1:0] exu_waddr,
   input  logic [DATA_WIDTH-1:0] exu_wdata,
   input  logic                  lsu_valid,
   output logic                  lsu_ready,
   input  logic [ADDR_WIDTH-1:0] lsu_waddr,
   input  logic [DATA_WIDTH-1:0] lsu_wdata,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   input  logic                  issue_valid,
   input  logic [ADDR_WIDTH-1:0] issue_waddr,
   output logic                  issue_ready,
   input  logic [ADDR_WIDTH-1:0] chk_raddr1,
   input  logic [ADDR_WIDTH-1:0] chk_raddr2,
   output logic                  stall
`ifdef RF_WB_BYPASS_EN
   ,
   output logic                  fwd1_valid,
   output logic                  fwd2_valid,
   output logic [DATA_WIDTH-1:0] fwd1_data,
   output logic [DATA_WIDTH-1:0] fwd2_data
`endif
);

   localparam int unsigned NREGS = 2 ** ADDR_WIDTH;
   localparam logic GRANT_EXU = 1'b0;
   localparam logic GRANT_LSU = 1'b1;

   logic                  last_grant;
   logic                  grant_exu;
   logic                  grant_lsu;
   logic                  accept;
   logic [ADDR_WIDTH-1:0] sel_waddr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [NREGS-1:0]      busy;
   logic [NREGS-1:0]      busy_next;
   logic                  clr_en;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic                  src1_hazard;
   logic                  src2_hazard;
   logic                  issue_fire;

   // Round-robin grant: a lone requester always wins, a tie goes to whoever lost last time.
   always_comb begin
      grant_exu = exu_valid && (!lsu_valid || (last_grant == GRANT_LSU));
      grant_lsu = lsu_valid && (!exu_valid || (last_grant == GRANT_EXU));
      accept    = grant_exu || grant_lsu;
      sel_waddr = grant_exu ? exu_waddr : lsu_waddr;
      sel_wdata = grant_exu ? exu_wdata : lsu_wdata;
   end

   assign exu_ready = grant_exu;
   assign lsu_ready = grant_lsu;

`ifdef RF_WB_BYPASS_EN
   // Data already sitting in the output stage is forwarded, so it no longer causes a stall.
   always_comb begin
      fwd1_valid = rf_wen && (rf_waddr == chk_raddr1) && (chk_raddr1 != '0);
      fwd2_valid = rf_wen && (rf_waddr == chk_raddr2) && (chk_raddr2 != '0);
      fwd1_data  = rf_wdata;
      fwd2_data  = rf_wdata;
      clr_en     = accept && (sel_waddr != '0);
      clr_addr   = sel_waddr;
   end
   assign src1_hazard = (chk_raddr1 != '0) && busy[chk_raddr1] && !fwd1_valid;
   assign src2_hazard = (chk_raddr2 != '0) && busy[chk_raddr2] && !fwd2_valid;
`else
   always_comb begin
      clr_en   = rf_wen;
      clr_addr = rf_waddr;
   end
   assign src1_hazard = (chk_raddr1 != '0) && busy[chk_raddr1];
   assign src2_hazard = (chk_raddr2 != '0) && busy[chk_raddr2];
`endif

   assign stall       = src1_hazard || src2_hazard;
   assign issue_ready = !busy[issue_waddr] || (issue_waddr == '0);
   assign issue_fire  = issue_valid && issue_ready && !stall;

   // Clear first, then set, so a new issue survives a writeback to the same register.
   always_comb begin
      busy_next = busy;
      if (clr_en) begin
         busy_next[clr_addr] = 1'b0;
      end
      if (issue_fire && (issue_waddr != '0)) begin
         busy_next[issue_waddr] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= GRANT_LSU;
         busy       <= '0;
         rf_wen     <= 1'b0;
         rf_waddr   <= '0;
         rf_wdata   <= '0;
      end else begin
         busy   <= busy_next;
         rf_wen <= accept && (sel_waddr != '0);
         if (accept) begin
            last_grant <= grant_exu ? GRANT_EXU : GRANT_LSU;
            rf_waddr   <= sel_waddr;
            rf_wdata   <= sel_wdata;
         end
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized + directed bench for rf_wb_arbiter against a cycle-level behavioural model.
// Honours RF_WB_BYPASS_EN when the design is built with it.
module tb_rf_wb_arbiter;

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          exu_valid, lsu_valid, issue_valid;
   logic          exu_ready, lsu_ready, issue_ready, stall;
   logic [AW-1:0] exu_waddr, lsu_waddr, issue_waddr, chk_raddr1, chk_raddr2;
   logic [DW-1:0] exu_wdata, lsu_wdata;
   logic          rf_wen;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
`ifdef RF_WB_BYPASS_EN
   logic          fwd1_valid, fwd2_valid;
   logic [DW-1:0] fwd1_data, fwd2_data;
`endif

   rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_waddr(exu_waddr), .exu_wdata(exu_wdata),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .issue_valid(issue_valid), .issue_waddr(issue_waddr), .issue_ready(issue_ready),
      .chk_raddr1(chk_raddr1), .chk_raddr2(chk_raddr2), .stall(stall)
`ifdef RF_WB_BYPASS_EN
      , .fwd1_valid(fwd1_valid), .fwd2_valid(fwd2_valid),
      .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
`endif
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Model state: who has priority on a tie, which registers are pending, what the RF port shows.
   bit          m_exu_first;
   bit [31:0]   m_busy;
   bit          m_wen;
   bit [AW-1:0] m_waddr;
   bit [DW-1:0] m_wdata;
   // Expected combinational values for the current inputs.
   bit          e_exu_rdy, e_lsu_rdy, e_iss_rdy, e_stall, e_fwd1, e_fwd2;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_exu_first = 1'b1;
      m_busy      = '0;
      m_wen       = 1'b0;
      m_waddr     = '0;
      m_wdata     = '0;
   endtask

   function automatic bit src_pending(input bit [AW-1:0] r, input bit fwd);
      if (r == 0) return 1'b0;
      if (fwd) return 1'b0;
      return m_busy[r];
   endfunction

   // Evaluate the model for the present inputs, compare, then advance it across one clock edge.
   task automatic tick();
      bit          acc;
      bit [AW-1:0] a;
      bit [DW-1:0] d;
      bit [31:0]   nb;
      #1;
      if (exu_valid && lsu_valid) begin
         e_exu_rdy = m_exu_first;
         e_lsu_rdy = !m_exu_first;
      end else begin
         e_exu_rdy = exu_valid;
         e_lsu_rdy = lsu_valid;
      end
`ifdef RF_WB_BYPASS_EN
      e_fwd1 = m_wen && (m_waddr == chk_raddr1) && (chk_raddr1 != 0);
      e_fwd2 = m_wen && (m_waddr == chk_raddr2) && (chk_raddr2 != 0);
`else
      e_fwd1 = 1'b0;
      e_fwd2 = 1'b0;
`endif
      e_stall   = src_pending(chk_raddr1, e_fwd1) || src_pending(chk_raddr2, e_fwd2);
      e_iss_rdy = (issue_waddr == 0) || !m_busy[issue_waddr];

      chk("exu_ready", 32'(exu_ready), 32'(e_exu_rdy));
      chk("lsu_ready", 32'(lsu_ready), 32'(e_lsu_rdy));
      chk("rf_wen", 32'(rf_wen), 32'(m_wen));
      chk("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
      chk("rf_wdata", rf_wdata, m_wdata);
      chk("issue_ready", 32'(issue_ready), 32'(e_iss_rdy));
      chk("stall", 32'(stall), 32'(e_stall));
`ifdef RF_WB_BYPASS_EN
      chk("fwd1_valid", 32'(fwd1_valid), 32'(e_fwd1));
      chk("fwd2_valid", 32'(fwd2_valid), 32'(e_fwd2));
      if (e_fwd1) chk("fwd1_data", fwd1_data, m_wdata);
      if (e_fwd2) chk("fwd2_data", fwd2_data, m_wdata);
`endif

      acc = e_exu_rdy || e_lsu_rdy;
      a   = e_exu_rdy ? exu_waddr : lsu_waddr;
      d   = e_exu_rdy ? exu_wdata : lsu_wdata;
      nb  = m_busy;
`ifdef RF_WB_BYPASS_EN
      if (acc && a != 0) nb[a] = 1'b0;
`else
      if (m_wen) nb[m_waddr] = 1'b0;
`endif
      if (issue_valid && e_iss_rdy && !e_stall && issue_waddr != 0) nb[issue_waddr] = 1'b1;

      @(posedge clk);
      if (rst) begin
         m_reset();
      end else begin
         m_busy = nb;
         m_wen  = acc && (a != 0);
         if (acc) begin
            m_exu_first = !e_exu_rdy;
            m_waddr     = a;
            m_wdata     = d;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      exu_valid = 0; lsu_valid = 0; issue_valid = 0;
      exu_waddr = 0; lsu_waddr = 0; issue_waddr = 0;
      exu_wdata = 0; lsu_wdata = 0;
      chk_raddr1 = 0; chk_raddr2 = 0;
   endtask

   task automatic exu_write(input bit [AW-1:0] a, input bit [DW-1:0] d);
      exu_valid = 1; exu_waddr = a; exu_wdata = d;
   endtask

   initial begin
      bit exu_pend, lsu_pend;
      int ea, lb;
      idle_inputs();
      rst = 1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      m_reset();

      // Reset state
      #1;
      chk("reset rf_wen", 32'(rf_wen), 32'd0);
      chk("reset rf_waddr", 32'(rf_waddr), 32'd0);
      chk("reset rf_wdata", rf_wdata, 32'd0);
      rst = 0;

      // 1: lone EXU request
      exu_write(3, 32'h11);
      #1 chk("t1 exu_ready", 32'(exu_ready), 32'd1);
      tick();
      exu_valid = 0;
      #1;
      chk("t1 rf_wen", 32'(rf_wen), 32'd1);
      chk("t1 rf_waddr", 32'(rf_waddr), 32'd3);
      chk("t1 rf_wdata", rf_wdata, 32'h11);
      tick();
      chk("t1 rf_wen low", 32'(rf_wen), 32'd0);

      // 2: contention alternates, starting with EXU after reset
      rst = 1; tick(); rst = 0;
      ea = 0; lb = 0;
      for (int c = 0; c < 4; c++) begin
         exu_write(1, 32'hA0 + 32'(ea));
         lsu_valid = 1; lsu_waddr = 2; lsu_wdata = 32'hB0 + 32'(lb);
         #1 chk("t2 exu_ready", 32'(exu_ready), 32'((c % 2) == 0));
         tick();
         chk("t2 rf_wdata", rf_wdata, (c % 2 == 0) ? 32'hA0 + 32'(c / 2) : 32'hB0 + 32'(c / 2));
         if (c % 2 == 0) ea++; else lb++;
      end
      idle_inputs();

      // 3: RAW stall on r5 until its write lands
      issue_valid = 1; issue_waddr = 5;
      tick();
      issue_valid = 0; chk_raddr1 = 5;
      exu_write(5, 32'h55);
      #1 chk("t3 stall busy", 32'(stall), 32'd1);
      tick();
      exu_valid = 0;
`ifdef RF_WB_BYPASS_EN
      #1 chk("t3 stall fwd", 32'(stall), 32'd0);
`else
      #1 chk("t3 stall in flight", 32'(stall), 32'd1);
`endif
      tick();
      chk("t3 stall after write", 32'(stall), 32'd0);
      chk_raddr1 = 0;

      // 4: WAW on r7, then set-wins on a coincident clear
      issue_valid = 1; issue_waddr = 7;
      tick();
      #1 chk("t4 waw ready", 32'(issue_ready), 32'd0);
      exu_write(7, 32'h77);
      tick();
      exu_valid = 0;
`ifdef RF_WB_BYPASS_EN
      #1 chk("t4 ready after accept", 32'(issue_ready), 32'd1);
      tick();
`else
      #1 chk("t4 ready in flight", 32'(issue_ready), 32'd0);
      tick();
      chk("t4 ready after write", 32'(issue_ready), 32'd1);
      tick();
`endif
      chk("t4 busy again", 32'(issue_ready), 32'd0);
      issue_valid = 0;
      exu_write(7, 32'h78);
      tick();
      exu_valid = 0;
      tick();
      exu_write(7, 32'h79);
`ifdef RF_WB_BYPASS_EN
      issue_valid = 1;
      tick();
      exu_valid = 0;
`else
      tick();
      exu_valid = 0; issue_valid = 1;
      #1 chk("t4 rf_wen 7", 32'(rf_wen), 32'd1);
      tick();
`endif
      issue_valid = 0;
      #1 chk("t4 set wins", 32'(issue_ready), 32'd0);
      exu_write(7, 32'h7A);
      tick();
      exu_valid = 0;
      tick();

      // 5: x0 handling
      lsu_valid = 1; lsu_waddr = 0; lsu_wdata = 32'hFF;
      #1 chk("t5 lsu_ready", 32'(lsu_ready), 32'd1);
      tick();
      lsu_valid = 0; issue_valid = 1; issue_waddr = 0;
      #1 chk("t5 rf_wen x0", 32'(rf_wen), 32'd0);
      tick();
      issue_valid = 0;
      #1;
      chk("t5 x0 never busy", 32'(issue_ready), 32'd1);
      chk("t5 stall x0", 32'(stall), 32'd0);

      // 6: reset in the middle of a tracked write
      issue_valid = 1; issue_waddr = 9;
      tick();
      issue_valid = 0;
      exu_write(9, 32'h99);
      tick();
      exu_valid = 0; chk_raddr1 = 9;
      #1 chk("t6 rf_wen", 32'(rf_wen), 32'd1);
`ifdef RF_WB_BYPASS_EN
      chk("t6 fwd1_valid", 32'(fwd1_valid), 32'd1);
      chk("t6 stall fwd", 32'(stall), 32'd0);
`endif
      rst = 1;
      tick();
      rst = 0;
      exu_write(4, 32'h44);
      lsu_valid = 1; lsu_waddr = 6; lsu_wdata = 32'h66;
      #1;
      chk("t6 rf_wen dropped", 32'(rf_wen), 32'd0);
      chk("t6 stall cleared", 32'(stall), 32'd0);
      chk("t6 exu first", 32'(exu_ready), 32'd1);
      tick();

      // Random traffic with held requests until accepted
      for (int c = 0; c < 3000; c++) begin
         exu_pend = exu_valid && !e_exu_rdy;
         lsu_pend = lsu_valid && !e_lsu_rdy;
         if (!exu_pend) begin
            exu_valid = ($urandom_range(0, 2) != 0);
            exu_waddr = AW'($urandom_range(0, 7));
            exu_wdata = $urandom;
         end
         if (!lsu_pend) begin
            lsu_valid = ($urandom_range(0, 2) != 0);
            lsu_waddr = AW'($urandom_range(0, 7));
            lsu_wdata = $urandom;
         end
         issue_valid = $urandom_range(0, 1) != 0;
         issue_waddr = AW'($urandom_range(0, 7));
         chk_raddr1  = AW'($urandom_range(0, 7));
         chk_raddr2  = AW'($urandom_range(0, 7));
         rst = ($urandom_range(0, 199) == 0);
         if (rst) begin
            exu_valid = 0;
            lsu_valid = 0;
         end
         tick();
         rst = 0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
